// File: rtl/dual_port_ram_if.sv
// Port bundle for the dual-port RAM: per-port enable, write enable, address,
// write data and registered read data for ports A and B.
// Ports: master drives requests and samples read data; slave is the RAM side.
interface dual_port_ram_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             ena;
  logic             wea;
  logic [AW-1:0]    addra;
  logic [WIDTH-1:0] dina;
  logic [WIDTH-1:0] douta;

  logic             enb;
  logic             web;
  logic [AW-1:0]    addrb;
  logic [WIDTH-1:0] dinb;
  logic [WIDTH-1:0] doutb;

  modport master (
    output ena, wea, addra, dina,
    output enb, web, addrb, dinb,
    input  douta, doutb
  );

  modport slave (
    input  ena, wea, addra, dina,
    input  enb, web, addrb, dinb,
    output douta, doutb
  );
endinterface

// File: rtl/dual_port_ram.sv
// Purpose: true dual-port synchronous RAM, two independent read/write ports on one clock.
// Latency: read data registered, valid exactly 1 clk after an enabled read.
// Backpressure: none; every enabled access completes in its cycle.
// Ports: clk, rst_n (async active-low, clears douta/doutb only), bus (slave modport):
//   ena/wea/addra/dina/douta for port A, enb/web/addrb/dinb/doutb for port B.
module dual_port_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  dual_port_ram_if.slave  bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam bit POW2 = ((1 << AW) == DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] douta_q, douta_d;
  logic [WIDTH-1:0] doutb_q, doutb_d;
  logic             a_ok, b_ok;

  // Address range check only matters when DEPTH leaves unused address codes.
  if (POW2) begin : g_pow2
    assign a_ok = 1'b1;
    assign b_ok = 1'b1;
  end else begin : g_npow2
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    assign a_ok = ({1'b0, bus.addra} < DEPTH_W);
    assign b_ok = ({1'b0, bus.addrb} < DEPTH_W);
  end

  // Array next-state. B is applied first so a same-address A write overrides it.
  // Gating on rst_n discards writes on any edge seen while reset is held.
  always_comb begin
    mem_d = mem_q;
    if (rst_n) begin
      if (bus.enb && bus.web && b_ok) mem_d[bus.addrb] = bus.dinb;
      if (bus.ena && bus.wea && a_ok) mem_d[bus.addra] = bus.dina;
    end
  end

  // Reads sample the pre-edge array, giving read-before-write on collisions.
  // Write cycles leave the output untouched (no-change mode).
  always_comb begin
    douta_d = douta_q;
    doutb_d = doutb_q;
    if (bus.ena && !bus.wea) douta_d = a_ok ? mem_q[bus.addra] : '0;
    if (bus.enb && !bus.web) doutb_d = b_ok ? mem_q[bus.addrb] : '0;
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      douta_q <= '0;
      doutb_q <= '0;
    end else begin
      douta_q <= douta_d;
      doutb_q <= doutb_d;
    end
  end

  assign bus.douta = douta_q;
  assign bus.doutb = doutb_q;
endmodule

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram: directed scenarios plus randomized traffic against
// an array-based reference model of the RAM's documented behaviour.
// Ports: none (top-level bench).
module tb_dual_port_ram;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  dual_port_ram_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  dual_port_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: word array with written flags, expected outputs.
  logic [WIDTH-1:0] ref_mem [DEPTH];
  bit               ref_vld [DEPTH];
  logic [WIDTH-1:0] ref_da, ref_db;
  bit               kn_a, kn_b;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit ea, input bit wa, input int aa, input logic [WIDTH-1:0] da,
                       input bit eb, input bit wb, input int ab, input logic [WIDTH-1:0] db);
    bus.ena   = ea;
    bus.wea   = wa;
    bus.addra = aa[1:0];
    bus.dina  = da;
    bus.enb   = eb;
    bus.web   = wb;
    bus.addrb = ab[1:0];
    bus.dinb  = db;
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, 0, 0, 0, '0);
  endtask

  // One clock: update the model from the inputs present at the edge, then check.
  task automatic step();
    int aa, ab;
    @(posedge clk);
    aa = int'(bus.addra);
    ab = int'(bus.addrb);
    if (rst_n) begin
      // Reads see contents from before this edge's writes.
      if (bus.ena && !bus.wea) begin
        ref_da = ref_mem[aa];
        kn_a   = ref_vld[aa];
      end
      if (bus.enb && !bus.web) begin
        ref_db = ref_mem[ab];
        kn_b   = ref_vld[ab];
      end
      // Same-address double write: port A's data is the one kept.
      if (bus.enb && bus.web) begin
        ref_mem[ab] = bus.dinb;
        ref_vld[ab] = 1'b1;
      end
      if (bus.ena && bus.wea) begin
        ref_mem[aa] = bus.dina;
        ref_vld[aa] = 1'b1;
      end
    end
    #1;
    if (kn_a) chk("model_douta", bus.douta, ref_da);
    if (kn_b) chk("model_doutb", bus.doutb, ref_db);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      ref_vld[i] = 1'b0;
    end
    ref_da = '0;
    ref_db = '0;
    kn_a   = 1'b1;
    kn_b   = 1'b1;

    // Reset state
    rst_n = 1'b0;
    idle();
    #1;
    chk("reset_douta", bus.douta, '0);
    chk("reset_doutb", bus.doutb, '0);
    step();
    step();
    rst_n = 1'b1;

    // Port A write then read; output holds across writes
    drive(1, 1, 0, 32'hA5A5A5A5, 0, 0, 0, '0); step();
    chk("a_wr0_hold", bus.douta, '0);
    drive(1, 1, 1, 32'h5A5A5A5A, 0, 0, 0, '0); step();
    chk("a_wr1_hold", bus.douta, '0);
    drive(1, 0, 0, '0, 0, 0, 0, '0); step();
    chk("a_rd0", bus.douta, 32'hA5A5A5A5);
    drive(1, 0, 1, '0, 0, 0, 0, '0); step();
    chk("a_rd1", bus.douta, 32'h5A5A5A5A);

    // Port B write then read
    drive(0, 0, 0, '0, 1, 1, 2, 32'h12345678); step();
    drive(0, 0, 0, '0, 1, 1, 3, 32'h87654321); step();
    chk("b_wr_hold", bus.doutb, '0);
    drive(0, 0, 0, '0, 1, 0, 2, '0); step();
    chk("b_rd2", bus.doutb, 32'h12345678);
    drive(0, 0, 0, '0, 1, 0, 3, '0); step();
    chk("b_rd3", bus.doutb, 32'h87654321);

    // Cross-port visibility
    drive(1, 0, 3, '0, 1, 0, 1, '0); step();
    chk("x_b_rd1", bus.doutb, 32'h5A5A5A5A);
    chk("x_a_rd3", bus.douta, 32'h87654321);

    // Enable gating
    drive(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, '0); step();
    chk("en_a_hold", bus.douta, 32'h87654321);
    drive(0, 0, 0, '0, 0, 0, 2, '0); step();
    drive(0, 0, 0, '0, 0, 1, 3, 32'hDEADBEEF); step();
    chk("en_b_hold", bus.doutb, 32'h5A5A5A5A);
    drive(1, 0, 0, '0, 1, 0, 3, '0); step();
    chk("en_a_nowr", bus.douta, 32'hA5A5A5A5);
    chk("en_b_nowr", bus.doutb, 32'h87654321);

    // Collisions: same-address writes, then write vs read
    drive(1, 1, 2, 32'h11111111, 1, 1, 2, 32'h22222222); step();
    drive(1, 0, 2, '0, 0, 0, 0, '0); step();
    chk("col_ww", bus.douta, 32'h11111111);
    drive(1, 1, 3, 32'h33333333, 1, 0, 3, '0); step();
    chk("col_rbw_old", bus.doutb, 32'h87654321);
    drive(0, 0, 0, '0, 1, 0, 3, '0); step();
    chk("col_rbw_new", bus.doutb, 32'h33333333);
    drive(1, 0, 3, '0, 1, 0, 3, '0); step();
    chk("col_rr_a", bus.douta, 32'h33333333);
    chk("col_rr_b", bus.doutb, 32'h33333333);

    // Reset asserted mid-operation with writes pending
    drive(1, 1, 0, 32'hCAFEF00D, 1, 1, 1, 32'hBADC0DE5);
    #3;
    rst_n  = 1'b0;
    ref_da = '0;
    ref_db = '0;
    #1;
    chk("rst_async_a", bus.douta, '0);
    chk("rst_async_b", bus.doutb, '0);
    step();
    chk("rst_held_a", bus.douta, '0);
    chk("rst_held_b", bus.doutb, '0);
    idle();
    rst_n = 1'b1;
    drive(1, 0, 0, '0, 1, 0, 1, '0); step();
    chk("rst_nowr_a", bus.douta, 32'hA5A5A5A5);
    chk("rst_nowr_b", bus.doutb, 32'h5A5A5A5A);

    // Randomized traffic, all addresses already written
    for (int i = 0; i < 400; i++) begin
      drive(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
            int'($urandom_range(0, DEPTH - 1)), $urandom,
            bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
            int'($urandom_range(0, DEPTH - 1)), $urandom);
      step();
    end
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
